// File: rtl/queue.sv
// queue: synchronous FIFO with registered outputs and register-array storage.
// A pop returns the oldest stored word on DATA_OUT one cycle after the accepting edge.
// Pointers wrap modulo DEPTH by natural overflow; COUNT separates full from empty.
// Optional macro QUEUE_ERR_FLAGS_EN adds the CLR_ERR input and the sticky
// OVERFLOW / UNDERFLOW outputs. Without it, rejected requests are dropped silently.

module queue #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    output logic [DATA_WIDTH-1:0]   DATA_OUT,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  COUNT
`ifdef QUEUE_ERR_FLAGS_EN
    ,
    input  logic                    CLR_ERR,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic popOk;
    logic pushOk;

    // When the queue is full, a push is accepted only if a pop frees a slot on the same edge.
    always_comb begin
        popOk     = POP & ~empty_q;
        pushOk    = PUSH & (~full_q | popOk);
        wrPtr_d   = pushOk ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d   = popOk  ? rdPtr_q + 1'b1 : rdPtr_q;
        dataOut_d = popOk  ? mem[rdPtr_q]   : dataOut_q;
        count_d   = count_q + {{PTR_W{1'b0}}, pushOk} - {{PTR_W{1'b0}}, popOk};
        full_d    = (count_d == CNT_W'(DEPTH));
        empty_d   = (count_d == '0);
    end

    // Storage array is not reset. When the queue is full and both requests are accepted,
    // the read and the write hit the same slot. The read sees the old word because of
    // the non-blocking write.
    always_ff @(posedge CLK) begin
        if (pushOk && !RST) begin
            mem[wrPtr_q] <= DATA_IN;
        end
    end

    // Pointers, occupancy, flags and the output word. Reset is asynchronous and
    // clears all of them at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dataOut_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            dataOut_q <= dataOut_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign DATA_OUT = dataOut_q;
    assign FULL     = full_q;
    assign EMPTY    = empty_q;
    assign COUNT    = count_q;

`ifdef QUEUE_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags. A set event on the same edge as CLR_ERR takes priority over the clear.
    always_comb begin
        overflow_d  = (PUSH & ~pushOk) | (overflow_q  & ~CLR_ERR);
        underflow_d = (POP & empty_q)  | (underflow_q & ~CLR_ERR);
    end

    // Error flag registers are cleared by reset together with the queue state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_queue.sv
// tb_queue: directed test for the queue FIFO with default parameters.
// Each step drives one clock edge. Outputs are checked 1 ns after that edge.

module tb_queue;

    logic       clock;
    logic       reset;
    logic       push;
    logic       pop;
    logic [1:0] dataIn;
    logic [1:0] dataOut;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef QUEUE_ERR_FLAGS_EN
    logic       clrErr;
    logic       overflow;
    logic       underflow;
`endif

    int testCount = 0;
    int failCount = 0;

    logic [1:0] expFullDrain [16] = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                      2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    queue #(.DATA_WIDTH(2), .DEPTH(16)) dut (
        .CLK      (clock),
        .RST      (reset),
        .PUSH     (push),
        .POP      (pop),
        .DATA_IN  (dataIn),
        .DATA_OUT (dataOut),
        .FULL     (full),
        .EMPTY    (empty),
        .COUNT    (count)
`ifdef QUEUE_ERR_FLAGS_EN
        ,
        .CLR_ERR  (clrErr),
        .OVERFLOW (overflow),
        .UNDERFLOW(underflow)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drives one request cycle, then releases the request lines 1 ns after the edge
    task automatic applyStimulus(input logic doPush, input logic doPop, input logic [1:0] word);
        push   = doPush;
        pop    = doPop;
        dataIn = word;
        @(posedge clock);
        #1;
        push   = 1'b0;
        pop    = 1'b0;
`ifdef QUEUE_ERR_FLAGS_EN
        clrErr = 1'b0;
`endif
    endtask

    // Compares one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Directed sequence of steps
    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        dataIn = 2'd0;
`ifdef QUEUE_ERR_FLAGS_EN
        clrErr = 1'b0;
`endif
        #12;
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_dout", 32'(dataOut), 0);
        reset = 1'b0;

        // 1: push 3,1,2 and pop them back in order
        applyStimulus(1, 0, 2'd3);
        applyStimulus(1, 0, 2'd1);
        applyStimulus(1, 0, 2'd2);
        checkOutput("t1_count3", 32'(count), 3);
        checkOutput("t1_notempty", 32'(empty), 0);
        applyStimulus(0, 1, 2'd0);
        checkOutput("t1_pop1", 32'(dataOut), 3);
        checkOutput("t1_count2", 32'(count), 2);
        applyStimulus(0, 1, 2'd0);
        checkOutput("t1_pop2", 32'(dataOut), 1);
        checkOutput("t1_count1", 32'(count), 1);
        applyStimulus(0, 1, 2'd0);
        checkOutput("t1_pop3", 32'(dataOut), 2);
        checkOutput("t1_count0", 32'(count), 0);
        checkOutput("t1_empty", 32'(empty), 1);
        applyStimulus(0, 0, 2'd0);
        checkOutput("t1_hold", 32'(dataOut), 2);

        // 2: fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 2'(i % 4));
        end
        checkOutput("t2_full", 32'(full), 1);
        checkOutput("t2_count16", 32'(count), 16);
        applyStimulus(1, 0, 2'd2);
        checkOutput("t2_ovf_count", 32'(count), 16);
        checkOutput("t2_ovf_full", 32'(full), 1);
`ifdef QUEUE_ERR_FLAGS_EN
        checkOutput("t2_overflow", 32'(overflow), 1);
        clrErr = 1'b1;
        applyStimulus(0, 0, 2'd0);
        checkOutput("t2_overflow_clr", 32'(overflow), 0);
`endif
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 2'd0);
            checkOutput($sformatf("t2_drain%0d", i), 32'(dataOut), 32'(i % 4));
        end
        checkOutput("t2_empty", 32'(empty), 1);
        checkOutput("t2_notfull", 32'(full), 0);

        // 3: pop while empty right after reset
        reset = 1'b1;
        #2;
        reset = 1'b0;
        applyStimulus(0, 1, 2'd0);
        checkOutput("t3_dout", 32'(dataOut), 0);
        checkOutput("t3_count", 32'(count), 0);
        checkOutput("t3_empty", 32'(empty), 1);
`ifdef QUEUE_ERR_FLAGS_EN
        checkOutput("t3_underflow", 32'(underflow), 1);
        clrErr = 1'b1;
        applyStimulus(0, 0, 2'd0);
        checkOutput("t3_underflow_clr", 32'(underflow), 0);
`endif

        // 4: simultaneous push/pop at COUNT=5, then at COUNT=16
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 2'(i % 4));
        end
        checkOutput("t4_count5", 32'(count), 5);
        applyStimulus(1, 1, 2'd3);
        checkOutput("t4_mid_count", 32'(count), 5);
        checkOutput("t4_mid_dout", 32'(dataOut), 0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 0, 2'(i % 4));
        end
        checkOutput("t4_full", 32'(full), 1);
        applyStimulus(1, 1, 2'd3);
        checkOutput("t4_full_dout", 32'(dataOut), 1);
        checkOutput("t4_full_count", 32'(count), 16);
        checkOutput("t4_full_stays", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 2'd0);
            checkOutput($sformatf("t4_drain%0d", i), 32'(dataOut), 32'(expFullDrain[i]));
        end
        checkOutput("t4_empty", 32'(empty), 1);

        // 5: 40-word stream with simultaneous push/pop across pointer wraps
        applyStimulus(1, 0, 2'd0);
        applyStimulus(1, 0, 2'd1);
        for (int i = 2; i < 40; i++) begin
            applyStimulus(1, 1, 2'(i % 4));
            checkOutput($sformatf("t5_stream%0d", i), 32'(dataOut), 32'((i - 2) % 4));
            checkOutput($sformatf("t5_count%0d", i), 32'(count), 2);
        end
        applyStimulus(0, 1, 2'd0);
        checkOutput("t5_tail0", 32'(dataOut), 2);
        applyStimulus(0, 1, 2'd0);
        checkOutput("t5_tail1", 32'(dataOut), 3);
        checkOutput("t5_empty", 32'(empty), 1);

        // 6: asynchronous reset with COUNT=7
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 2'd1);
        end
        checkOutput("t6_count7", 32'(count), 7);
        reset = 1'b1;
        #2;
        checkOutput("t6_rst_count", 32'(count), 0);
        checkOutput("t6_rst_empty", 32'(empty), 1);
        checkOutput("t6_rst_full", 32'(full), 0);
        checkOutput("t6_rst_dout", 32'(dataOut), 0);
        reset = 1'b0;
        applyStimulus(0, 1, 2'd0);
        checkOutput("t6_pop_rej_count", 32'(count), 0);
        checkOutput("t6_pop_rej_dout", 32'(dataOut), 0);
        applyStimulus(1, 0, 2'd1);
        checkOutput("t6_push_count", 32'(count), 1);
        applyStimulus(0, 1, 2'd0);
        checkOutput("t6_pop_dout", 32'(dataOut), 1);
        checkOutput("t6_pop_empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
